// File: rtl/debug_unit.sv
// Host debug controller: decodes UART commands, gates pipeline advance, counts
// executed cycles and streams a PC / cycle-count / register-file dump as bytes.
module debug_unit #(
   parameter int NB_REG        = 32,
   parameter int NB_BYTE       = 8,
   parameter int NB_REG_ADDR   = 5,
   parameter int REGFILE_DEPTH = 32
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic [NB_BYTE-1:0]     i_rx_data,
   input  logic                   i_rx_valid,
   output logic [NB_BYTE-1:0]     o_tx_data,
   output logic                   o_tx_valid,
   input  logic                   i_tx_ready,
   output logic                   o_valid,
   input  logic                   i_halt,
   input  logic [NB_REG-1:0]      i_pc,
   output logic [NB_REG_ADDR-1:0] o_reg_addr,
   input  logic [NB_REG-1:0]      i_reg_data,
   output logic                   o_busy
);
   localparam int NB_BYTES = NB_REG / NB_BYTE;
   localparam int NB_BCNT  = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
   localparam int N_WORDS  = REGFILE_DEPTH + 2;
   localparam int NB_WCNT  = $clog2(N_WORDS + 1);

   localparam logic [NB_BYTE-1:0] CMD_RUN  = NB_BYTE'('h63);
   localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'('h73);
   localparam logic [NB_BYTE-1:0] CMD_DUMP = NB_BYTE'('h64);

   typedef enum logic [2:0] {
      ST_IDLE, ST_RUN, ST_STEP, ST_LOAD, ST_CAP, ST_SEND
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [NB_WCNT-1:0]   r_word;
   logic [NB_BCNT-1:0]   r_byte;
   logic [NB_REG-1:0]    r_cycle;
   logic [NB_REG-1:0]    r_pc_snap;
   logic [NB_REG-1:0]    r_shift;
   logic                 w_enter_dump;
   logic                 w_accept;
   logic                 w_last_byte;
   logic                 w_last_word;

   assign w_accept     = (r_state == ST_SEND) && i_tx_ready;
   assign w_last_byte  = (r_byte == NB_BCNT'(NB_BYTES - 1));
   assign w_last_word  = (r_word == NB_WCNT'(N_WORDS - 1));
   assign w_enter_dump = (w_next == ST_LOAD) &&
                         (r_state inside {ST_IDLE, ST_RUN, ST_STEP});

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_word  <= '0;
         r_byte  <= '0;
         r_cycle <= '0;
      end else begin
         r_state <= w_next;
         if (o_valid)
            r_cycle <= r_cycle + 1'b1;
         if (w_enter_dump)
            r_word <= '0;
         else if (w_accept && w_last_byte)
            r_word <= r_word + 1'b1;
         if (w_accept)
            r_byte <= w_last_byte ? '0 : r_byte + 1'b1;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (i_rx_valid) begin
               if (i_rx_data == CMD_DUMP)
                  w_next = ST_LOAD;
               else if (i_rx_data == CMD_RUN)
                  w_next = i_halt ? ST_LOAD : ST_RUN;
               else if (i_rx_data == CMD_STEP)
                  w_next = i_halt ? ST_LOAD : ST_STEP;
            end
         end
         ST_RUN:  if (i_halt) w_next = ST_LOAD;
         ST_STEP: w_next = ST_LOAD;
         // PC and cycle words load directly; registers need a capture cycle
         ST_LOAD: w_next = (r_word < NB_WCNT'(2)) ? ST_SEND : ST_CAP;
         ST_CAP:  w_next = ST_SEND;
         ST_SEND: begin
            if (w_accept && w_last_byte)
               w_next = w_last_word ? ST_IDLE : ST_LOAD;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      o_valid    = (r_state == ST_RUN) || (r_state == ST_STEP);
      o_busy     = (r_state != ST_IDLE);
      o_tx_valid = (r_state == ST_SEND);
      o_tx_data  = (r_state == ST_SEND) ? r_shift[NB_REG-1 -: NB_BYTE] : '0;
      o_reg_addr = '0;
      if ((r_state == ST_LOAD) && (r_word >= NB_WCNT'(2)))
         o_reg_addr = NB_REG_ADDR'(r_word - NB_WCNT'(2));
   end

   // Counter is frozen while dumping, so it is read live at its load slot
   always_ff @(posedge i_clock) begin
      if (w_enter_dump)
         r_pc_snap <= i_pc;
      case (r_state)
         ST_LOAD: begin
            if (r_word == NB_WCNT'(0))
               r_shift <= r_pc_snap;
            else if (r_word == NB_WCNT'(1))
               r_shift <= r_cycle;
         end
         ST_CAP:  r_shift <= i_reg_data;
         ST_SEND: if (i_tx_ready) r_shift <= r_shift << NB_BYTE;
         default: ;
      endcase
   end
endmodule

// File: doc/debug_unit.md
# debug_unit

Host-side control and readout block for the MIPS pipeline. It takes command bytes from the UART receiver and gates the pipeline's `i_valid` for free-run or single-step execution. It counts executed cycles and streams a snapshot of PC, cycle count and register file back to the UART transmitter over a valid/ready byte interface. It sits between the UART pair and the pipeline top.

## Interface
Parameters:
- `NB_REG`, 32, data word width (must be a multiple of `NB_BYTE`).
- `NB_BYTE`, 8, UART byte width.
- `NB_REG_ADDR`, 5, register file address width.
- `REGFILE_DEPTH`, 32, number of registers dumped.

Ports:
- `i_clock`  in  1  system clock; all state on rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_rx_data`  in  `NB_BYTE`  received command byte.
- `i_rx_valid`  in  1  one-cycle strobe, `i_rx_data` valid.
- `o_tx_data`  out  `NB_BYTE`  byte to transmit.
- `o_tx_valid`  out  1  `o_tx_data` valid; held until accepted.
- `i_tx_ready`  in  1  transmitter accepts the byte on a cycle with `o_tx_valid & i_tx_ready`.
- `o_valid`  out  1  pipeline advance enable (drives pipeline `i_valid`).
- `i_halt`  in  1  pipeline has retired HALT; level.
- `i_pc`  in  `NB_REG`  current pipeline PC.
- `o_reg_addr`  out  `NB_REG_ADDR`  debug read address into register file.
- `i_reg_data`  in  `NB_REG`  register data; valid one cycle after `o_reg_addr` changes (synchronous read).
- `o_busy`  out  1  high whenever state is not IDLE.

## Operation
Commands are accepted only in IDLE. Bytes received in any other state are dropped. Unknown bytes are ignored.
- 0x63 'c': run. If `i_halt` is already high, go to DUMP. Otherwise go to RUN.
- 0x73 's': step. If `i_halt` is already high, go to DUMP. Otherwise go to STEP.
- 0x64 'd': go to DUMP.

States:
- IDLE: no activity.
- RUN: `o_valid`=1 every cycle. When `i_halt`=1 is sampled at a clock edge, go to DUMP.
- STEP: `o_valid`=1 for exactly one cycle, then go to DUMP.
- DUMP_LOAD: load the next word into a `NB_REG`-bit shift register.
- DUMP_SEND: emit the shift register bytes.
- Return to IDLE after the last byte is accepted.

`o_valid` is decoded from state: high iff state is RUN or STEP.

Cycle counter:
- `NB_REG` bits.
- Increments on every edge where `o_valid`=1.
- Wraps from 2^NB_REG-1 to 0.
- Cleared only by reset and persists across commands.

Dump sequence, words in order:
- word 0 = `i_pc`, sampled at DUMP entry.
- word 1 = cycle count, sampled at DUMP entry.
- words 2 .. REGFILE_DEPTH+1 = registers 0 .. REGFILE_DEPTH-1.

Byte order and count:
- Each word is sent MSB byte first as `NB_REG`/`NB_BYTE` bytes.
- Total is 4*(REGFILE_DEPTH+2) = 136 bytes at default parameters.

Register reads:
- `o_reg_addr` is set to the register index in the DUMP_LOAD cycle.
- `i_reg_data` is captured on the following edge.
- Each register word therefore costs one load cycle plus one capture cycle before its first byte is offered.
- `o_reg_addr` holds 0 outside register loads.

TX handshake:
- `o_tx_valid` stays high and `o_tx_data` stays stable until `i_tx_ready`.
- On acceptance the next byte appears the next cycle, or the unit moves to the next word or to IDLE.
- `i_tx_ready` held low stalls indefinitely with no data loss.

## Timing
- Reset values:
  - state IDLE.
  - `o_valid`=0, `o_tx_valid`=0, `o_tx_data`=0, `o_reg_addr`=0, `o_busy`=0.
  - cycle counter = 0.
- Reset asserted mid-RUN or mid-DUMP: all of the above take effect immediately (asynchronously). The partial dump is abandoned and nothing is resent after release.
- Command latency:
  - `i_rx_valid` sampled at edge N moves state at edge N; `o_valid` and `o_busy` are high during cycle N+1.
  - 'd' at edge N gives the first `o_tx_valid` no later than cycle N+2.
- STEP: exactly one `o_valid` cycle, so the counter increments by exactly 1.
- RUN with halt:
  - `i_halt` rising during cycle K is sampled at edge K.
  - `o_valid` is low from cycle K+1.
  - The cycle-K `o_valid` counts.
- Simultaneous `i_rx_valid` and a DUMP completion at the same edge: the byte is dropped (state was not IDLE).

## Test plan
- Reset, then 'd' with `i_tx_ready`=1, `i_pc`=0x00000010 and regfile r[i]=i -> 136 bytes: 00 00 00 10, 00 00 00 00, 00 00 00 00, 00 00 00 01, …, 00 00 00 1F; `o_busy` then falls.
- 's' three times, each dump completing -> cycle-count word reads 1, 2, 3; each step shows exactly one `o_valid` cycle.
- 'c' with `i_halt` driven high 20 cycles after `o_valid` rises -> exactly 21 `o_valid` cycles, count word = 21, then dump; a further 'c' with `i_halt` still high -> zero `o_valid` cycles, count still 21.
- Dump with `i_tx_ready` toggling pseudo-randomly, plus bytes 0x63 and 0x73 injected mid-dump -> byte stream identical to the stall-free case, injected bytes ignored, no `o_valid` pulse.
- Cycle counter forced to 0xFFFFFFFF via backdoor, then 's' -> count word 0x00000000.
- Async reset pulsed mid-RUN and mid-dump (after byte 50) -> `o_valid`, `o_tx_valid` and `o_busy` drop without waiting for a clock edge; counter reads 0 in the next dump.
